fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage: owns the PC register, drives imem_pc into the combinational
//   instruction memory and captures imem_instr plus its PC into the IF/ID pipeline register.
//   Feeds decode over a valid/ready handshake. Accepts redirects (branch/jump) from execute.
//   Stops fetching on a halt word.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset; must be word aligned
//   HALT_WORD  32'h0000_0000  fetched word that halts fetch
//   CNT_W      32             width of fetch_count
// PORTS
//   clk              in   1   rising-edge clock
//   rst_n            in   1   asynchronous, active-low reset
//   redirect_valid   in   1   load redirect_target as the next PC this cycle
//   redirect_target  in   32  byte address of the redirect
//   imem_pc          out  32  address to instruction memory; always equals pc_q
//   imem_instr       in   32  instruction word returned combinationally for imem_pc
//   id_valid         out  1   IF/ID register holds a valid instruction
//   id_ready         in   1   decode accepts the IF/ID entry this cycle
//   id_instr         out  32  captured instruction
//   id_pc            out  32  PC of id_instr
//   id_pc_plus4      out  32  id_pc + 4 (mod 2^32)
//   halted           out  1   fetch stopped on HALT_WORD
//   fetch_count      out  CNT_W  number of instructions loaded into IF/ID
//   misalign_trap    out  1   sticky; present only with FETCH_MISALIGN_TRAP_EN
// BEHAVIOUR
//   Reset (async, rst_n=0): pc_q=RESET_PC, state=BOOT, id_valid=0, id_instr=0, id_pc=0,
//     id_pc_plus4=0, halted=0, fetch_count=0, misalign_trap=0. A mid-operation reset discards everything.
//   States: BOOT -> RUN (unconditional, 1 cycle; no load in BOOT, the memory read settles).
//     RUN -> HALTED when a word equal to HALT_WORD is loaded into IF/ID.
//     HALTED -> RUN only on redirect_valid.
//   load = (state==RUN) && (!id_valid || id_ready) && !redirect_valid.
//     On load: IF/ID <= {imem_instr, pc_q, pc_q+4}, id_valid<=1, pc_q<=pc_q+4, fetch_count++.
//     A loaded HALT_WORD is delivered to decode, but pc_q does not advance. halted=1 from the next cycle.
//   Stall: id_valid && !id_ready && !redirect_valid -> IF/ID and pc_q are held.
//   Consume without load (id_ready, state!=RUN) -> id_valid<=0.
//   Redirect has the highest priority, in any state except BOOT (ignored in BOOT):
//     pc_q <= {redirect_target[31:2],2'b00}, id_valid<=0 (flush), halted<=0, state<=RUN.
//     The first target instruction reaches IF/ID one cycle later (1 bubble).
//   Latency: imem_pc -> id_instr is 1 clock. Throughput is 1 instr/cycle when id_ready=1.
//   Wrap-around: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag. fetch_count wraps at 2^CNT_W.
//   Redirect together with id_ready=1: the entry counts as consumed and is flushed, with no new load.
// CONFIGURATION
//   FETCH_MISALIGN_TRAP_EN defined:
//     A redirect with target[1:0]!=0 flushes IF/ID, leaves pc_q unchanged,
//     sets misalign_trap=1 (sticky until reset) and enters HALTED.
//     Later redirects are ignored while misalign_trap=1.
//   Not defined: the low two bits are silently cleared and the misalign_trap port does not exist.
// STRUCTURE
//   Package fetch_pkg:
//     state encoding BOOT/RUN/HALTED (2 bits), INSTR_BYTES=4, ALIGN_MASK=32'hFFFF_FFFC.
//   Sub-module if_id_register:
//     holds instr/pc/pc_plus4/valid with load, flush and hold controls.
//     The PC/FSM logic stays in fetch_stage.
// TESTING
//   1. Reset, memory words 0x00500093,0x00100113,..., id_ready=1
//      -> id_pc 0,4,8 on consecutive cycles from cycle 2; fetch_count increments by 1 per cycle.
//   2. id_ready=0 for 3 cycles with id_pc=8
//      -> id_instr, id_pc and imem_pc=12 are held; on release, id_pc=12 the next cycle.
//   3. redirect_valid, target 0x40, while id_valid=1 and stalled
//      -> id_valid=0 next cycle, imem_pc=0x40, id_pc=0x40 one cycle later.
//   4. HALT_WORD at address 0x10
//      -> id_instr=0 delivered, halted=1, imem_pc stays 0x10.
//      -> redirect to 0x0 clears halted and restarts at 0x0.
//   5. Redirect target 0x42
//      -> without the macro: imem_pc=0x40.
//      -> with FETCH_MISALIGN_TRAP_EN: misalign_trap=1, halted=1, pc unchanged.
//   6. rst_n pulsed low mid-stream, asynchronously between edges
//      -> all outputs are at reset values immediately; fetch restarts at RESET_PC after the BOOT cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// =============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and constants for the instruction-fetch stage.
// Rev     : 1.0
// =============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_register.sv
// =============================================================================
// Module  : if_id_register
// Brief   : IF/ID pipeline register (instr, pc, pc+4, valid) with flush/load/consume.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module if_id_register
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_consume,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;

    // Flush beats load beats consume; with none of them the entry is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_instr    <= 32'd0;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + INSTR_BYTES;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// =============================================================================
// Module  : fetch_stage
// Brief   : PC register, fetch FSM and IF/ID feed; optional FETCH_MISALIGN_TRAP_EN.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_pc,
    input  logic [31:0]      imem_instr,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_plus4,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic             misalign_trap
`endif
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [CNT_W-1:0] r_count;

    logic w_redir;
    logic w_redir_bad;
    logic w_load;
    logic w_consume;
    logic w_halt_hit;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_trap;

    // Once trapped, the stage stays halted until reset.
    assign w_redir     = redirect_valid && (r_state != BOOT) && !r_trap;
    assign w_redir_bad = w_redir && (redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else if (w_redir_bad) begin
            r_trap <= 1'b1;
        end
    end

    assign misalign_trap = r_trap;
`else
    assign w_redir     = redirect_valid && (r_state != BOOT);
    assign w_redir_bad = 1'b0;
`endif

    assign w_load     = (r_state == RUN) && (!id_valid || id_ready) && !redirect_valid;
    assign w_consume  = id_valid && id_ready;
    assign w_halt_hit = w_load && (imem_instr == HALT_WORD);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     if (w_halt_hit) w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = BOOT;
        endcase
        // A halt word is delivered but the PC stays parked on it.
        if (w_load && !w_halt_hit) begin
            w_pc_nxt = r_pc + INSTR_BYTES;
        end
        if (w_redir) begin
            if (w_redir_bad) begin
                w_state_nxt = HALTED;
            end else begin
                w_state_nxt = RUN;
                w_pc_nxt    = align_pc(redirect_target);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_load) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    if_id_register u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_flush    (w_redir),
        .i_consume  (w_consume),
        .i_instr    (imem_instr),
        .i_pc       (r_pc),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc       (id_pc),
        .o_pc_plus4 (id_pc_plus4)
    );

    assign imem_pc     = r_pc;
    assign halted      = (r_state == HALTED);
    assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// =============================================================================
// Module  : tb_fetch_stage
// Brief   : Randomized scoreboard bench for fetch_stage (FETCH_MISALIGN_TRAP_EN aware).
// Rev     : 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;
    localparam logic [31:0] HI_KEY    = 32'h1357_9BDF;

    logic        clk             = 1'b0;
    logic        rst_n           = 1'b0;
    logic        redirect_valid  = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        id_ready        = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;
    logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .HALT_WORD (HALT_WORD),
        .CNT_W     (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_pc         (imem_pc),
        .imem_instr      (imem_instr),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .halted          (halted),
        .fetch_count     (fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap   (misalign_trap)
`endif
    );

    // Instruction memory: 64 words at 0x00..0xFC, a fixed nonzero pattern elsewhere.
    logic [31:0] mem [64];
    assign imem_instr = (imem_pc < 32'h100) ? mem[imem_pc[7:2]] : ((imem_pc ^ HI_KEY) | 32'h1);

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h100) return mem[a[7:2]];
        return (a ^ HI_KEY) | 32'h1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the expected IF/ID contents as a queue of fetched words.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    ent_t        exp_q[$];
    int          m_mode = 0;     // 0 boot, 1 run, 2 halted
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_cnt  = 32'd0;
    bit          m_trap = 1'b0;

    task automatic model_step();
        ent_t e;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (redirect_valid && !m_trap) begin
            exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_target[1:0] != 2'b00) begin
                m_trap = 1'b1;
                m_mode = 2;
            end else
`endif
            begin
                m_pc   = redirect_target & ~32'h3;
                m_mode = 1;
            end
        end else if (m_mode == 1 && exp_q.size() == 0 && !redirect_valid) begin
            e.instr = mem_word(m_pc);
            e.pc    = m_pc;
            e.pc4   = m_pc + 32'd4;
            exp_q.push_back(e);
            m_cnt   = m_cnt + 32'd1;
            if (e.instr == HALT_WORD) m_mode = 2;
            else                      m_pc   = m_pc + 32'd4;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            m_mode = 0;
            m_pc   = RESET_PC;
            m_cnt  = 32'd0;
            m_trap = 1'b0;
        end else begin
            model_step();
        end
    end

    // Monitor: one negedge ahead of the edge that acts on the current inputs.
    initial forever begin
        ent_t e;
        @(negedge clk);
        chk("id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() != 0});
        chk("imem_pc", imem_pc, m_pc);
        chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
        chk("fetch_count", fetch_count, m_cnt);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trap});
`endif
        if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_entry: got pc %h with nothing expected", id_pc);
            end else begin
                e = exp_q.pop_front();
                chk("id_instr", id_instr, e.instr);
                chk("id_pc", id_pc, e.pc);
                chk("id_pc_plus4", id_pc_plus4, e.pc4);
            end
        end
    end

    task automatic cyc(input bit rdy, input bit red, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        id_ready        = rdy;
        redirect_valid  = red;
        redirect_target = tgt;
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(rdy, 1'b0, 32'd0);
    endtask

    task automatic rand_cycles(input int n);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0:       t = 32'hFFFF_FFF8;
                1:       t = $urandom_range(0, 255);
                default: t = $urandom_range(0, 63) << 2;
            endcase
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, t);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        mem[0]  = 32'h0050_0093;
        mem[1]  = 32'h0010_0113;
        mem[2]  = 32'h0020_81B3;
        mem[3]  = 32'h0000_0013;
        mem[4]  = HALT_WORD;
        mem[40] = HALT_WORD;
        mem[57] = HALT_WORD;

        run(3, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(4, 1'b1);                    // stream 0,4,8
        run(3, 1'b0);                    // stall
        run(1, 1'b1);
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 32'h40);         // redirect while stalled
        run(8, 1'b1);
        cyc(1'b1, 1'b1, 32'h0);
        run(10, 1'b1);                   // reaches halt word at 0x10
        run(3, 1'b0);
        cyc(1'b1, 1'b1, 32'h0);          // restart from halt
        run(3, 1'b1);
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8);  // wrap-around
        run(4, 1'b1);
        cyc(1'b1, 1'b1, 32'h42);         // misaligned target
        run(4, 1'b1);

        rand_cycles(2000);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_imem_pc", imem_pc, RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misalign_trap", {31'd0, misalign_trap}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(6, 1'b1);
        rand_cycles(300);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
